systolic_result_collector: RTL and testbench

- Sits at the output end of systolic_array. Takes the N_SIZE result rows the array streams out, one row per cycle on its valid_out/matrix_c_out pair, and stores the full N_SIZE x N_SIZE result matrix.
- Once the matrix is complete, it drains the elements one at a time, in row-major order, through a valid/ready stream to downstream logic such as a DMA or writeback block.
- The array has no backpressure, so the collector flags any row that arrives while it is draining.

---
 rtl/systolic_result_collector_if.sv | 31 +++
 rtl/systolic_result_collector.sv | 118 +++++++++++
 tb/tb_systolic_result_collector.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_collector_if.sv
// Bundle between the systolic array output, the result collector and the downstream element stream.
// The collector binds to the slave modport; the producer/consumer side uses master.
interface systolic_result_collector_if #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
);
  localparam int EW = 2 * DATAWIDTH;
  localparam int IW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;

  logic                   valid_in;
  logic [N_SIZE*EW-1:0]   matrix_c_in;
  logic                   in_ready;
  logic                   c_valid;
  logic                   c_ready;
  logic [EW-1:0]          c_data;
  logic [IW-1:0]          c_row;
  logic [IW-1:0]          c_col;
  logic                   c_last;
  logic                   frame_done;
  logic                   overflow;

  modport master (
    output valid_in, matrix_c_in, c_ready,
    input  in_ready, c_valid, c_data, c_row, c_col, c_last, frame_done, overflow
  );

  modport slave (
    input  valid_in, matrix_c_in, c_ready,
    output in_ready, c_valid, c_data, c_row, c_col, c_last, frame_done, overflow
  );
endinterface

// File: rtl/systolic_result_collector.sv
// Buffers one N_SIZE x N_SIZE result matrix from the systolic array and replays it
// row-major over a valid/ready stream; rows arriving mid-drain are dropped and flagged.
module systolic_result_collector #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  systolic_result_collector_if.slave bus
);
  localparam int EW = 2 * DATAWIDTH;
  localparam int IW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_SIZE - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] row_cnt;
  logic [IW-1:0] c_row;
  logic [IW-1:0] c_col;
  logic [IW-1:0] nxt_row;
  logic [IW-1:0] nxt_col;
  logic [EW-1:0] mem [N_SIZE][N_SIZE];
  logic [EW-1:0] c_data;
  logic          c_valid;
  logic          c_last;
  logic          in_ready;
  logic          frame_done;
  logic          overflow;
  logic          capture;

  assign capture = (state == COLLECT) && bus.valid_in;

  always_comb begin
    nxt_col = c_col + IW'(1);
    nxt_row = c_row;
    if (c_col == LAST) begin
      nxt_col = '0;
      nxt_row = c_row + IW'(1);
    end
  end

  // Row buffer: data only, never reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int j = 0; j < N_SIZE; j++) begin
        mem[row_cnt][j] <= bus.matrix_c_in[j*EW +: EW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      row_cnt    <= '0;
      c_row      <= '0;
      c_col      <= '0;
      c_valid    <= 1'b0;
      c_data     <= '0;
      c_last     <= 1'b0;
      in_ready   <= 1'b1;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.valid_in) begin
            if (row_cnt == LAST) begin
              row_cnt    <= '0;
              state      <= DRAIN;
              frame_done <= 1'b1;
              c_valid    <= 1'b1;
              c_row      <= '0;
              c_col      <= '0;
              // With a single row, element (0,0) is still on the input bus this edge.
              c_data     <= (N_SIZE == 1) ? bus.matrix_c_in[EW-1:0] : mem[0][0];
              c_last     <= (N_SIZE == 1);
              in_ready   <= 1'b0;
            end else begin
              row_cnt <= row_cnt + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.valid_in) begin
            overflow <= 1'b1;
          end
          if (c_valid && bus.c_ready) begin
            if (c_last) begin
              state    <= COLLECT;
              c_valid  <= 1'b0;
              c_data   <= '0;
              c_last   <= 1'b0;
              c_row    <= '0;
              c_col    <= '0;
              in_ready <= 1'b1;
            end else begin
              c_row  <= nxt_row;
              c_col  <= nxt_col;
              c_data <= mem[nxt_row][nxt_col];
              c_last <= (nxt_row == LAST) && (nxt_col == LAST);
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.c_valid    = c_valid;
  assign bus.c_data     = c_data;
  assign bus.c_row      = c_row;
  assign bus.c_col      = c_col;
  assign bus.c_last     = c_last;
  assign bus.frame_done = frame_done;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed and randomized frames checked against a row-major queue model of the expected element stream.
module tb_systolic_result_collector;
  localparam int DW = 16;
  localparam int N  = 5;
  localparam int EW = 2 * DW;

  typedef struct {
    logic [EW-1:0] d;
    int            r;
    int            c;
  } elem_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   cyc;

  logic [EW-1:0] mat [N][N];
  elem_t         q[$];

  always #5 clk = ~clk;

  systolic_result_collector_if #(.DATAWIDTH(DW), .N_SIZE(N)) bus ();

  systolic_result_collector #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_c_valid"}, bus.c_valid, 0);
    chk({tag, "_c_data"}, bus.c_data, 0);
    chk({tag, "_c_row"}, bus.c_row, 0);
    chk({tag, "_c_col"}, bus.c_col, 0);
    chk({tag, "_c_last"}, bus.c_last, 0);
  endtask

  // kind 0: C[r][c] = r<<16 | c; kind 1: random; kind 2: pattern with two marker values in row 4.
  task automatic fill(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = (kind == 1) ? EW'($urandom) : ((EW'(r) << 16) | EW'(c));
    if (kind == 2) begin
      mat[4][4] = 32'hDEADBEEF;
      mat[4][0] = 32'h00000001;
    end
  endtask

  function automatic logic [N*EW-1:0] row_vec(input int r);
    logic [N*EW-1:0] v;
    for (int j = 0; j < N; j++) v[j*EW +: EW] = mat[r][j];
    return v;
  endfunction

  task automatic send_frame(input int gap);
    for (int r = 0; r < N; r++) begin
      chk("collect_in_ready", bus.in_ready, 1);
      chk("collect_c_valid", bus.c_valid, 0);
      chk("collect_c_data", bus.c_data, 0);
      bus.valid_in    = 1'b1;
      bus.matrix_c_in = row_vec(r);
      tick();
      bus.valid_in    = 1'b0;
      bus.matrix_c_in = '0;
      if (r < N - 1) begin
        chk("frame_done_early", bus.frame_done, 0);
        repeat (gap) tick();
      end
    end
    chk("frame_done_pulse", bus.frame_done, 1);
    chk("drain_entry_valid", bus.c_valid, 1);
    chk("drain_entry_in_ready", bus.in_ready, 0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        q.push_back('{mat[r][c], r, c});
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,1,0..; mode 2: random ready.
  task automatic drain(input int mode, input int inject_at, input int stop_at, output int cycles);
    int idx = 0;
    bit rdy;
    bit seen_ff = 1'b0;
    cycles = 0;
    while (q.size() > 0 && cycles < 400) begin
      if (idx == stop_at) break;
      chk("drain_c_valid", bus.c_valid, 1);
      chk("drain_c_data", bus.c_data, q[0].d);
      chk("drain_c_row", bus.c_row, q[0].r);
      chk("drain_c_col", bus.c_col, q[0].c);
      chk("drain_c_last", bus.c_last, (q[0].r == N - 1 && q[0].c == N - 1) ? 1 : 0);
      chk("drain_in_ready", bus.in_ready, 0);
      if (cycles > 0) chk("drain_frame_done", bus.frame_done, 0);
      if (bus.c_data == 32'hFFFFFFFF) seen_ff = 1'b1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.c_ready = rdy;
      if (idx == inject_at && rdy) begin
        bus.valid_in    = 1'b1;
        bus.matrix_c_in = '1;
      end
      tick();
      bus.valid_in    = 1'b0;
      bus.matrix_c_in = '0;
      bus.c_ready     = 1'b0;
      cycles++;
      if (rdy) begin
        void'(q.pop_front());
        idx++;
      end
    end
    if (stop_at < 0) begin
      chk("drain_complete", q.size(), 0);
      chk_idle("post_drain");
      chk("no_dropped_row_seen", seen_ff, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.valid_in    = 1'b0;
    bus.matrix_c_in = '0;
    bus.c_ready     = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_frame_done", bus.frame_done, 0);
    chk("reset_overflow", bus.overflow, 0);
    rst = 1'b0;
    tick();

    // Consecutive rows, ready held high.
    fill(0);
    send_frame(0);
    drain(0, -1, -1, cyc);
    chk("s1_drain_cycles", cyc, 25);
    chk("s1_overflow", bus.overflow, 0);

    // Ready toggling 1,0,1,0.
    fill(0);
    send_frame(0);
    drain(1, -1, -1, cyc);
    chk("s2_drain_cycles", cyc, 49);

    // Two idle cycles between rows.
    fill(0);
    send_frame(2);
    drain(0, -1, -1, cyc);
    chk("s3_drain_cycles", cyc, 25);

    // Extra row injected at the third drain element.
    fill(1);
    send_frame(0);
    drain(0, 2, -1, cyc);
    chk("s4_overflow_set", bus.overflow, 1);
    fill(1);
    send_frame(0);
    drain(2, -1, -1, cyc);
    chk("s4_overflow_sticky", bus.overflow, 1);

    // Reset while element (1,2) is presented.
    fill(0);
    send_frame(0);
    drain(0, -1, 7, cyc);
    chk("s5_pre_reset_row", bus.c_row, 1);
    chk("s5_pre_reset_col", bus.c_col, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("s5_reset");
    chk("s5_reset_overflow", bus.overflow, 0);
    chk("s5_reset_frame_done", bus.frame_done, 0);
    q.delete();
    fill(1);
    send_frame(0);
    drain(0, -1, -1, cyc);
    chk("s5_drain_cycles", cyc, 25);

    // Marker values to confirm column slicing and c_last on (4,4).
    fill(2);
    send_frame(0);
    drain(2, -1, -1, cyc);
    chk("s6_overflow_clear", bus.overflow, 0);

    // Row arriving on the c_last transfer edge is dropped; next frame starts back-to-back.
    fill(0);
    send_frame(0);
    drain(0, 24, -1, cyc);
    chk("s7_overflow_on_last", bus.overflow, 1);
    fill(1);
    send_frame(0);
    drain(0, -1, -1, cyc);
    chk("s7_next_frame_cycles", cyc, 25);

    // Randomized frames with random row gaps and random ready.
    for (int k = 0; k < 3; k++) begin
      fill(1);
      send_frame(int'($urandom_range(0, 3)));
      drain(2, -1, -1, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
